pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter generator.
package pc_pkg;

    localparam int XLEN_DEF       = 64;
    localparam int INST_BYTES_DEF = 4;
    localparam int RAS_DEPTH_DEF  = 4;

    // Source of the next PC value, in decreasing priority order after SEQ.
    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        TRAP   = 2'd1,
        BRANCH = 2'd2,
        RET    = 2'd3
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the
// oldest entry; push together with pop replaces the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][XLEN-1:0] mem_q;
    logic [PW-1:0]              ptr_q, ptr_d, wr_idx;
    logic [PW:0]                cnt_q, cnt_d;
    logic                       wr_en;

    assign top_o   = mem_q[ptr_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            // Wrapping the pointer lands on the oldest slot once full.
            ptr_d  = ptr_q + 1'b1;
            wr_idx = ptr_q + 1'b1;
            wr_en  = 1'b1;
            if (!full_o) cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en) mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > branch > return > sequential, with an optional
// return-address stack built only when PC_GEN_RAS_EN is defined.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              INST_BYTES = INST_BYTES_DEF,
    parameter int              RAS_DEPTH  = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            call_valid,
    input  logic            ret_valid,
    output logic [XLEN-1:0] inst_addr,
    output logic            redirect,
    output logic            ret_miss,
    output logic            misalign
);

    localparam int              LSB       = $clog2(INST_BYTES);
    localparam logic [XLEN-1:0] STEP      = XLEN'(INST_BYTES);
    localparam logic            RESET_MIS = |RESET_VEC[LSB-1:0];

    logic [XLEN-1:0] pc_q, pc_d, seq_pc;
    logic            redirect_q, ret_miss_q, misalign_q;
    pc_src_e         src;
    logic            load, miss;
    logic            call_en;
    logic            ras_push, ras_pop, ras_clear, ras_empty;
    logic [XLEN-1:0] ras_top;

`ifdef PC_GEN_RAS_EN
    logic ras_full;
    logic unused_ras_full;

    assign call_en         = call_valid;
    assign unused_ras_full = ras_full;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .clear_i (ras_clear),
        .data_i  (seq_pc),
        .top_o   (ras_top),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras;

    // Without a stack every return misses and calls degrade to branches.
    assign call_en    = 1'b0;
    assign ras_empty  = 1'b1;
    assign ras_top    = '0;
    assign unused_ras = ^{ras_push, ras_pop, ras_clear, call_valid};
`endif

    always_comb begin
        seq_pc    = pc_q + STEP;
        pc_d      = seq_pc;
        src       = SEQ;
        load      = en;
        miss      = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        ras_clear = 1'b0;
        if (trap_valid) begin
            src       = TRAP;
            pc_d      = trap_vec;
            load      = 1'b1;
            ras_clear = 1'b1;
        end else if (br_valid) begin
            src      = BRANCH;
            pc_d     = br_target;
            load     = 1'b1;
            // A stalled call still redirects but must not touch the stack.
            ras_push = call_en & en;
            ras_pop  = call_en & en & ret_valid & ~ras_empty;
        end else if (en && ret_valid) begin
            if (!ras_empty) begin
                src     = RET;
                pc_d    = ras_top;
                ras_pop = 1'b1;
            end else begin
                miss = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            ret_miss_q <= 1'b0;
            misalign_q <= RESET_MIS;
        end else begin
            redirect_q <= load && (src != SEQ);
            ret_miss_q <= miss;
            if (load) begin
                pc_q       <= pc_d;
                misalign_q <= |pc_d[LSB-1:0];
            end
        end
    end

    assign inst_addr = pc_q;
    assign redirect  = redirect_q;
    assign ret_miss  = ret_miss_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; return-stack expectations follow PC_GEN_RAS_EN.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, trap_valid, br_valid, call_valid, ret_valid;
    logic [63:0] trap_vec, br_target;
    logic [63:0] inst_addr;
    logic        redirect, ret_miss, misalign;

    int n_assert = 0;
    int n_fail   = 0;

    pc_gen dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .trap_valid (trap_valid),
        .trap_vec   (trap_vec),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .call_valid (call_valid),
        .ret_valid  (ret_valid),
        .inst_addr  (inst_addr),
        .redirect   (redirect),
        .ret_miss   (ret_miss),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b0; trap_valid = 1'b0; br_valid = 1'b0;
        call_valid = 1'b0; ret_valid = 1'b0;
    endtask

    task automatic expect_pc(input string tag, input logic [63:0] pc,
                             input logic rd, input logic rm);
        chk({tag, ".pc"}, inst_addr, pc);
        chk({tag, ".redirect"}, 64'(redirect), 64'(rd));
        chk({tag, ".ret_miss"}, 64'(ret_miss), 64'(rm));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        trap_vec = '0; br_target = '0;
        #3;
        expect_pc("reset", 64'h0, 1'b0, 1'b0);
        chk("reset.misalign", 64'(misalign), 64'h0);

        reset = 1'b1; en = 1'b1;
        tick(); expect_pc("seq1", 64'h4, 1'b0, 1'b0);
        tick(); expect_pc("seq2", 64'h8, 1'b0, 1'b0);
        tick(); expect_pc("seq3", 64'hC, 1'b0, 1'b0);

        // Branch while stalled, then hold, then trap beats branch.
        en = 1'b0; br_valid = 1'b1; br_target = 64'h1000;
        tick(); expect_pc("br_stall", 64'h1000, 1'b1, 1'b0);
        br_valid = 1'b0;
        tick(); expect_pc("hold", 64'h1000, 1'b0, 1'b0);
        br_valid = 1'b1; trap_valid = 1'b1; trap_vec = 64'h80;
        tick(); expect_pc("trap_prio", 64'h80, 1'b1, 1'b0);

        // Misaligned target is loaded unmodified.
        idle(); en = 1'b1; br_valid = 1'b1; br_target = 64'h1002;
        tick(); expect_pc("mis_br", 64'h1002, 1'b1, 1'b0);
        chk("mis_br.misalign", 64'(misalign), 64'h1);
        br_valid = 1'b0;
        tick(); chk("mis_seq.pc", inst_addr, 64'h1006);
        chk("mis_seq.misalign", 64'(misalign), 64'h1);
        br_valid = 1'b1; br_target = 64'h100;
        tick(); chk("align.misalign", 64'(misalign), 64'h0);

        // Call at 0x100 to 0x2000, then return.
        call_valid = 1'b1; br_target = 64'h2000;
        tick(); expect_pc("call", 64'h2000, 1'b1, 1'b0);
        idle(); en = 1'b1; ret_valid = 1'b1;
`ifdef PC_GEN_RAS_EN
        tick(); expect_pc("ret", 64'h104, 1'b1, 1'b0);
        ret_valid = 1'b0;
        tick(); expect_pc("ret_after", 64'h108, 1'b0, 1'b0);

        // Five calls into a four-deep stack; the oldest (0x504) is lost.
        idle(); en = 1'b1; br_valid = 1'b1; br_target = 64'h500;
        tick();
        call_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            br_target = 64'h3000 + 64'(i) * 64'h100;
            tick();
        end
        chk("calls.pc", inst_addr, 64'h3400);
        idle(); en = 1'b1; ret_valid = 1'b1;
        tick(); expect_pc("pop1", 64'h3304, 1'b1, 1'b0);
        tick(); expect_pc("pop2", 64'h3204, 1'b1, 1'b0);
        tick(); expect_pc("pop3", 64'h3104, 1'b1, 1'b0);
        tick(); expect_pc("pop4", 64'h3004, 1'b1, 1'b0);
        tick(); expect_pc("pop5_miss", 64'h3008, 1'b0, 1'b1);

        // Call plus return replaces the top without changing occupancy.
        idle(); en = 1'b1; br_valid = 1'b1; call_valid = 1'b1; br_target = 64'h4000;
        tick(); expect_pc("call_a", 64'h4000, 1'b1, 1'b0);
        ret_valid = 1'b1; br_target = 64'h5000;
        tick(); expect_pc("callret", 64'h5000, 1'b1, 1'b0);
        idle(); en = 1'b1; ret_valid = 1'b1;
        tick(); expect_pc("swap_pop", 64'h4004, 1'b1, 1'b0);
        tick(); expect_pc("swap_empty", 64'h4008, 1'b0, 1'b1);

        // Trap empties the stack.
        idle(); en = 1'b1; br_valid = 1'b1; call_valid = 1'b1; br_target = 64'h6000;
        tick();
        idle(); trap_valid = 1'b1; trap_vec = 64'h80; call_valid = 1'b1; ret_valid = 1'b1;
        tick(); expect_pc("trap_clr", 64'h80, 1'b1, 1'b0);
        idle(); en = 1'b1; ret_valid = 1'b1;
        tick(); expect_pc("trap_miss", 64'h84, 1'b0, 1'b1);

        // Stalled return leaves the stack alone.
        idle(); en = 1'b1; br_valid = 1'b1; call_valid = 1'b1; br_target = 64'h7000;
        tick();
        idle(); ret_valid = 1'b1;
        tick(); expect_pc("ret_stall", 64'h7000, 1'b0, 1'b0);
        en = 1'b1;
        tick(); expect_pc("ret_late", 64'h88, 1'b1, 1'b0);
`else
        tick(); expect_pc("ret_noras", 64'h2004, 1'b0, 1'b1);
        ret_valid = 1'b0;
        tick(); expect_pc("ret_noras_after", 64'h2008, 1'b0, 1'b0);
`endif

        // Sequential wrap at the top of the address space.
        idle(); en = 1'b1; br_valid = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); chk("wrap_pre", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        br_valid = 1'b0;
        tick(); expect_pc("wrap", 64'h0, 1'b0, 1'b0);
        tick(); chk("wrap_next", inst_addr, 64'h4);

        // Asynchronous reset with a pending branch.
        br_valid = 1'b1; br_target = 64'h9000;
        tick(); expect_pc("pre_rst", 64'h9000, 1'b1, 1'b0);
        #2 reset = 1'b0;
        #1 expect_pc("async_rst", 64'h0, 1'b0, 1'b0);
        tick(); chk("rst_hold", inst_addr, 64'h0);
        reset = 1'b1; br_valid = 1'b0;
        tick(); expect_pc("rst_release", 64'h4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
